// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the $0 address, default address/data widths and the pending-write record.
// The record fields are valid, destination register and write data.
package rf_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    // Writes to $0 are architectural no-ops.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One queued MDU write at the default widths.
    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] wa;
        logic [DW_DEF-1:0] din;
    } pending_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Circular buffer of pending MDU register-file writes, DEPTH entries.
// Latency: a push becomes visible at the head one cycle later; head and flags are combinational from state.
// Backpressure: full is exported and the caller must not push when full unless it also pops.
// Ports:
//   clk, rst                     clock, async active-high reset
//   push, push_wa, push_din      enqueue request and payload
//   pop                          dequeue the head entry
//   kill_en, kill_wa             clear valid on every entry (including the one pushed now) with this address
//   head_vld, head_wa, head_din  head entry
//   full, empty                  occupancy flags
//   ent_vld, ent_wa              per-entry valid/address vectors for the busy compare
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [AW-1:0]          push_wa,
    input  logic [DW-1:0]          push_din,
    input  logic                   pop,
    input  logic                   kill_en,
    input  logic [AW-1:0]          kill_wa,
    output logic                   head_vld,
    output logic [AW-1:0]          head_wa,
    output logic [DW-1:0]          head_din,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       ent_vld,
    output logic [DEPTH-1:0][AW-1:0] ent_wa
);

    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [PW:0]             r_count;
    logic [DEPTH-1:0]        r_vld;
    logic [DEPTH-1:0][AW-1:0] r_wa;
    logic [DEPTH-1:0][DW-1:0] r_din;

    // An entry pushed together with a WB write to the same register is
    // born dead: the WB value is newer and must not be overwritten.
    logic w_push_vld;
    assign w_push_vld = !(kill_en && (kill_wa == push_wa));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (r_wa[i] == kill_wa)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            // Push comes last so that when full with a simultaneous pop
            // (wptr == rptr) the new entry's valid bit wins.
            if (push) begin
                r_vld[r_wptr] <= w_push_vld;
                r_wptr        <= r_wptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            r_wa[r_wptr]  <= push_wa;
            r_din[r_wptr] <= push_din;
        end
    end

    assign head_vld = r_vld[r_rptr];
    assign head_wa  = r_wa[r_rptr];
    assign head_din = r_din[r_rptr];
    assign full     = (r_count == (PW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign ent_vld  = r_vld;
    assign ent_wa   = r_wa;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port between WB (priority) and the MDU, queueing MDU results that lose.
// Latency: port outputs are combinational in the same cycle; queued MDU writes drain on later free cycles.
// Backpressure: mdu_ready drops when the queue is full and no entry drains this cycle.
// Ports:
//   clk, rst                     clock, async active-high reset (queued writes are dropped)
//   wb_we, wb_wa, wb_din         WB stage write request
//   mdu_valid, mdu_wa, mdu_din   MDU result; mdu_ready = accepted this cycle
//   rf_we, rf_wa, rf_din         to the register file write port
//   chk_ra0/1 -> busy0/1         pending queued write to the given read address
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_din,
    input  logic          mdu_valid,
    input  logic [AW-1:0] mdu_wa,
    input  logic [DW-1:0] mdu_din,
    output logic          mdu_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_din,
    input  logic [AW-1:0] chk_ra0,
    input  logic [AW-1:0] chk_ra1,
    output logic          busy0,
    output logic          busy1
);

    logic                    w_wb_req;
    logic                    w_mdu_nz;
    logic                    w_pop;
    logic                    w_bypass;
    logic                    w_push;
    logic                    w_head_vld;
    logic [AW-1:0]           w_head_wa;
    logic [DW-1:0]           w_head_din;
    logic                    w_full;
    logic                    w_empty;
    logic [DEPTH-1:0]        w_ent_vld;
    logic [DEPTH-1:0][AW-1:0] w_ent_wa;

    // A WB write to $0 is not a request: the port stays free for the MDU.
    assign w_wb_req = wb_we && (wb_wa != AW'(REG_ZERO));
    assign w_mdu_nz = mdu_valid && (mdu_wa != AW'(REG_ZERO));

    // The head drains whenever WB leaves the port free, even if killed.
    assign w_pop    = !w_wb_req && !w_empty;
    // Bypass only with an empty queue so MDU writes stay in order.
    assign w_bypass = !w_wb_req && w_empty && w_mdu_nz;

    assign mdu_ready = !w_full || w_pop;
    // $0 results are accepted but never enqueued.
    assign w_push    = w_mdu_nz && mdu_ready && !w_bypass;

    rf_wr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_wa  (mdu_wa),
        .push_din (mdu_din),
        .pop      (w_pop),
        .kill_en  (w_wb_req),
        .kill_wa  (wb_wa),
        .head_vld (w_head_vld),
        .head_wa  (w_head_wa),
        .head_din (w_head_din),
        .full     (w_full),
        .empty    (w_empty),
        .ent_vld  (w_ent_vld),
        .ent_wa   (w_ent_wa)
    );

    always_comb begin
        rf_we  = 1'b0;
        rf_wa  = wb_wa;
        rf_din = wb_din;
        if (w_wb_req) begin
            rf_we  = 1'b1;
            rf_wa  = wb_wa;
            rf_din = wb_din;
        end else if (w_pop) begin
            rf_we  = w_head_vld;
            rf_wa  = w_head_wa;
            rf_din = w_head_din;
        end else if (w_bypass) begin
            rf_we  = 1'b1;
            rf_wa  = mdu_wa;
            rf_din = mdu_din;
        end
        // No write may reach the register file while reset is held.
        if (rst) begin
            rf_we = 1'b0;
        end
    end

    // Only queued entries mark a register busy; a bypassed write lands
    // this cycle and needs no stall.
    always_comb begin
        busy0 = 1'b0;
        busy1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i] && (w_ent_wa[i] == chk_ra0)) busy0 = 1'b1;
            if (w_ent_vld[i] && (w_ent_wa[i] == chk_ra1)) busy1 = 1'b1;
        end
        if (chk_ra0 == AW'(REG_ZERO)) busy0 = 1'b0;
        if (chk_ra1 == AW'(REG_ZERO)) busy1 = 1'b0;
    end

endmodule
